// File: rtl/count_seq_pkg.sv
// Shared types and default sizing for the count sequencer.
package count_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam int DEF_WIDTH    = 7;
  localparam int DEF_PRESCALE = 10;

endpackage

// File: rtl/count_prescaler.sv
// Free-running divide-by-PRESCALE phase counter; tick marks the last phase.
module count_prescaler
#(
  parameter int PRESCALE = 10,
  parameter int PS_W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_reg;

  assign tick = en && (ps_reg == PS_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_reg <= '0;
    end else if (clr) begin
      ps_reg <= '0;
    end else if (en) begin
      ps_reg <= tick ? '0 : ps_reg + PS_W'(1);
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Sequencer for a prescaled up-counter: start/stop/clear commands,
// one-shot or periodic terminal-count handling.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int PS_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done,
  output logic [1:0]       state
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] limit_reg, limit_next;
  logic             done_reg, done_next;
  logic             running_reg;
  logic             start_load;
  logic             ps_en;
  logic             ps_clr;
  logic             tick;

  // stop outranks start, so a coincident stop also blocks a fresh load.
  assign start_load = !clear && !stop && start && (limit != '0) &&
                      ((state_reg == IDLE) || (state_reg == DONE));
  assign ps_clr     = clear || start_load;
  // Gating with stop keeps the prescaler phase frozen on the pausing edge.
  assign ps_en      = (state_reg == RUN) && !stop && !clear;

  count_prescaler #(
    .PRESCALE (PRESCALE),
    .PS_W     (PS_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (ps_en),
    .clr  (ps_clr),
    .tick (tick)
  );

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    limit_next = limit_reg;
    done_next  = 1'b0;
    if (clear) begin
      state_next = IDLE;
      count_next = '0;
    end else begin
      unique case (state_reg)
        IDLE, DONE: begin
          if (start_load) begin
            limit_next = limit;
            count_next = '0;
            state_next = RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_next = PAUSE;
          end else if (tick) begin
            if (count_reg >= limit_reg) begin
              done_next = 1'b1;
              if (mode) begin
                count_next = '0;
              end else begin
                state_next = DONE;
              end
            end else begin
              count_next = count_reg + WIDTH'(1);
            end
          end
        end
        PAUSE: begin
          if (start && !stop) begin
            state_next = RUN;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      limit_reg   <= '0;
      done_reg    <= 1'b0;
      running_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      limit_reg   <= limit_next;
      done_reg    <= done_next;
      running_reg <= (state_next == RUN);
    end
  end

  assign count   = count_reg;
  assign running = running_reg;
  assign done    = done_reg;
  assign state   = state_reg;

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Control block that sequences a WIDTH-bit up-counter datapath: prescaled count enable, terminal-count detection, one-shot or periodic operation, and start/stop/clear command handling.
- Sits between front-panel/host command strobes and the counter.
- Runs in the 10 MHz system clock domain; count rate is clk/PRESCALE.

Parameters:
- WIDTH, 7, count and limit width.
- PRESCALE, 10, clk cycles per count step (>=2).
- PS_W, 4, prescaler register width; must satisfy 2^PS_W >= PRESCALE.

Ports:
- clk  input  1  system clock; single clock domain, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  command strobe: start from IDLE/DONE, or resume from PAUSE.
- stop  input  1  command strobe: pause while in RUN.
- clear  input  1  command strobe: abort and return to IDLE with count 0.
- mode  input  1  0 = one-shot, 1 = periodic; sampled on every terminal tick.
- limit  input  WIDTH  terminal count value; latched on start from IDLE/DONE.
- count  output  WIDTH  current count, registered.
- running  output  1  high while state is RUN.
- done  output  1  one-cycle pulse on every terminal event.
- state  output  2  current FSM state encoding (debug visibility).

Behaviour:
- Reset values: state=IDLE, count=0, prescaler=0, limit_q=0, done=0, running=0.
- States and encoding: IDLE=00, RUN=01, PAUSE=10, DONE=11.
- Command priority when strobes coincide on one edge: rst > clear > stop > start.
- clear, any state: next edge gives state=IDLE, count=0, prescaler=0, done=0.
- IDLE/DONE + start with limit!=0: limit_q<=limit, count<=0, prescaler<=0, state<=RUN.
- IDLE/DONE + start with limit==0: start is rejected and the state is unchanged.
- RUN + stop: state<=PAUSE; count and prescaler hold their values.
- RUN + start: ignored.
- PAUSE + start: state<=RUN, resuming from the held prescaler and count; limit_q is not reloaded.
- PAUSE + stop: ignored.
- Prescaler:
  - Advances only in RUN and wraps at PRESCALE-1.
  - tick = (state==RUN) && (prescaler==PRESCALE-1).
  - First count step occurs PRESCALE cycles after entering RUN.
- On tick with count<limit_q: count<=count+1.
- On tick with count==limit_q:
  - done<=1 for exactly one cycle.
  - mode=0: state<=DONE, count holds limit_q.
  - mode=1: count<=0, prescaler wraps, state stays RUN.
- stop and tick on the same edge: stop wins; no increment, no done.
- Arithmetic: count never exceeds limit_q, so no WIDTH overflow is possible. The prescaler is unsigned PS_W bits.
- Output timing: running and state are registered and change on the same edge as the FSM. done is registered, aligned with the count update edge.
- rst during RUN: all outputs take reset values on the next edge; an in-flight done is squashed.
- limit changes while in RUN/PAUSE have no effect until the next start from IDLE/DONE.

Decomposition:
- Shared package count_seq_pkg contains:
  - state typedef and encodings IDLE/RUN/PAUSE/DONE;
  - default WIDTH=7 and PRESCALE=10 constants.
- Sub-module count_prescaler:
  - ports clk, rst, en, clr, tick;
  - parameters PRESCALE and PS_W;
  - instantiated once, with en=(state==RUN) and clr driven on start-from-IDLE/DONE and on clear.
- FSM, limit register and count register live in count_sequencer.

Test Plan:
- Reset, then one-shot run: rst high 1 cycle, mode=0, limit=5, pulse start.
  - running=1 on the next edge.
  - count steps 1..5 every 10 cycles.
  - done pulses once, 60 cycles after running rose; state=DONE, count=5.
- Periodic run: mode=1, limit=99, start, run 2100 cycles.
  - count wraps 99->0 every 1000 cycles.
  - done pulses exactly twice.
  - running stays 1.
- Pause and resume: limit=20, start; stop when count=7 plus 3 prescale phases; wait 50 cycles; start.
  - count holds 7 during PAUSE.
  - After resume, count=8 arrives 7 cycles later.
  - done arrives at the original total run time plus 50 cycles.
- Simultaneous commands:
  - In RUN, assert stop and clear on the same edge -> IDLE, count=0.
  - In PAUSE, assert start and stop together -> stays PAUSE.
  - At a tick edge, assert stop -> PAUSE with count unchanged.
- Rejects and latching:
  - start with limit=0 -> state stays IDLE.
  - start with limit=3, then change limit to 50 during RUN -> one-shot terminates at count=3.
- Reset mid-operation: rst in RUN at count=42 -> all outputs reset next edge, no done pulse; a later start runs normally from 0.
